// File: rtl/hs_cdc_gray_rptr_ctrl.sv
// Read-side pointer controller for an async FIFO: validates the synchronized Gray
// write pointer, tracks occupancy, grants pops and owns the Gray read pointer.
module hs_cdc_gray_rptr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  gray_err,
  input  logic                  err_clr
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wg_q, wg_d;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic          gray_err_q, gray_err_d;

  logic [PW-1:0] diff;
  logic          multi_bit;
  logic          one_bit;
  logic          overflow;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Sample validation, occupancy, pop grant and next-state computation
  always_comb begin
    wg_d        = wg_q;
    wbin_d      = wbin_q;
    rbin_d      = rbin_q;
    rptr_gray_d = rptr_gray_q;
    gray_err_d  = gray_err_q;

    diff      = wptr_gray_sync ^ wg_q;
    multi_bit = |(diff & (diff - PW'(1)));
    one_bit   = (diff != '0) && !multi_bit;

    count    = wbin_q - rbin_q;
    empty    = (count == '0);
    overflow = (count > PW'(DEPTH));
    rd_grant = rd_req & ~empty;

    if (one_bit) begin
      wg_d   = wptr_gray_sync;
      wbin_d = gray2bin(wptr_gray_sync);
    end

    if (rd_grant) begin
      rbin_d      = rbin_q + PW'(1);
      rptr_gray_d = rbin_d ^ (rbin_d >> 1);
    end

    // A fresh error outranks a same-cycle clear
    if (multi_bit || overflow) begin
      gray_err_d = 1'b1;
    end else if (err_clr) begin
      gray_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wg_q        <= '0;
      wbin_q      <= '0;
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      gray_err_q  <= 1'b0;
    end else begin
      wg_q        <= wg_d;
      wbin_q      <= wbin_d;
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      gray_err_q  <= gray_err_d;
    end
  end

  assign raddr     = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray = rptr_gray_q;
  assign gray_err  = gray_err_q;

endmodule
